spart_rx: RTL and testbench

Receive half of the SPART serial port: recovers 8N1 asynchronous frames from the `rxd` line using 16x oversampling. It delivers each byte to the bus-side register logic with a data-available flag, framing-error flag and overrun flag. It sits beside the SPART transmit path and shares its baud divisor value, the `{db_high, db_low}` register pair.

---
 rtl/spart_pkg.sv | 18 +
 rtl/spart_rx_if.sv | 20 ++
 rtl/spart_baud_gen.sv | 34 +++
 rtl/spart_rx.sv | 110 +++++++++++
 tb/tb_spart_rx.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART serial port.
//   rx_state_t     : receive FSM states
//   OVERSAMPLE_DEF : default sample ticks per bit
//   FRAME_BITS     : data bits per frame
package spart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned FRAME_BITS     = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

endpackage

// File: rtl/spart_rx_if.sv
// Bus-side handshake between the SPART receiver and the register logic.
//   rd_ack      : bus has read rx_data (one-cycle pulse)
//   rx_data     : last accepted byte
//   rda         : received data available
//   framing_err : stop bit of the held byte was low
//   overrun     : a byte was dropped while rda was set
// master = bus/register side, slave = receiver.
interface spart_rx_if;
   import spart_pkg::*;

   logic                  rd_ack;
   logic [FRAME_BITS-1:0] rx_data;
   logic                  rda;
   logic                  framing_err;
   logic                  overrun;

   modport master (output rd_ack, input rx_data, rda, framing_err, overrun);
   modport slave  (input rd_ack, output rx_data, rda, framing_err, overrun);

endinterface

// File: rtl/spart_baud_gen.sv
// Baud tick generator: down-counter reloading from baud_div at zero.
//   clk, rst_n : clock, async active-low reset
//   baud_div   : tick period minus one; sampled only on reload
//   tick       : high for the one cycle the counter is zero
module spart_baud_gen #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] baud_div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nxt;

   // Reload at zero so a new divisor only lands at a period boundary.
   always_comb begin
      cnt_nxt = cnt - 1'b1;
      if (cnt == '0) cnt_nxt = baud_div;
   end

   // tick is registered alongside cnt so it always equals (cnt == 0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt_nxt;
         tick <= (cnt_nxt == '0);
      end
   end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 frame recovery with oversampling.
//   clk, rst_n : clock, async active-low reset
//   baud_div   : divisor shared with the transmit path
//   rxd        : asynchronous serial input, idle high
//   bus        : slave side of spart_rx_if (rd_ack in; data and flags out)
module spart_rx import spart_pkg::*; #(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned DIV_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             rxd,
   spart_rx_if.slave        bus
);

   localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(FRAME_BITS);

   rx_state_t             state, state_nxt;
   logic [1:0]            sync_q;
   logic                  rxd_s;
   logic                  tick;
   logic [SCNT_W-1:0]     scnt;
   logic [BIT_W-1:0]      bit_idx;
   logic [FRAME_BITS-1:0] shreg;
   logic                  scnt_mid_c, scnt_max_c;
   logic                  shift_c, done_c;

   spart_baud_gen #(.DIV_W(DIV_W)) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_div (baud_div),
      .tick     (tick)
   );

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], rxd};
   end
   assign rxd_s = sync_q[1];

   assign scnt_mid_c = (scnt == SCNT_W'(OVERSAMPLE/2 - 1));
   assign scnt_max_c = (scnt == SCNT_W'(OVERSAMPLE - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and per-cycle strobes.
   always_comb begin
      state_nxt = state;
      shift_c   = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE:  if (tick && !rxd_s) state_nxt = START;
         START: if (tick && scnt_mid_c) state_nxt = rxd_s ? IDLE : DATA;
         DATA:  if (tick && scnt_max_c) begin
                   shift_c = 1'b1;
                   if (bit_idx == BIT_W'(FRAME_BITS - 1)) state_nxt = STOP;
                end
         STOP:  if (tick && scnt_max_c) begin
                   done_c    = 1'b1;
                   state_nxt = rxd_s ? IDLE : BREAK;
                end
         BREAK: if (rxd_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Tick counter, bit index and LSB-first shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (state_nxt != state) scnt <= '0;
         else if (tick)          scnt <= scnt_max_c ? '0 : scnt + 1'b1;
         if (state_nxt == DATA && state != DATA) bit_idx <= '0;
         else if (shift_c)                       bit_idx <= bit_idx + 1'b1;
         if (shift_c) shreg <= {rxd_s, shreg[FRAME_BITS-1:1]};
      end
   end

   // Status flags: a completing frame wins over rd_ack for rda/framing_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rx_data     <= '0;
         bus.rda         <= 1'b0;
         bus.framing_err <= 1'b0;
         bus.overrun     <= 1'b0;
      end else begin
         if (done_c && (!bus.rda || bus.rd_ack)) begin
            bus.rx_data     <= shreg;
            bus.rda         <= 1'b1;
            bus.framing_err <= ~rxd_s;
         end else if (bus.rd_ack && bus.rda) begin
            bus.rda         <= 1'b0;
            bus.framing_err <= 1'b0;
         end
         if (done_c && bus.rda && !bus.rd_ack) bus.overrun <= 1'b1;
         else if (bus.rd_ack && bus.rda)       bus.overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spart_rx.sv
// Directed testbench for spart_rx: basic receive, glitch rejection,
// framing error with held-low line, overrun, same-cycle ack, reset
// mid-frame and +/-3% baud mismatch.
`timescale 1ns/1ps
module tb_spart_rx;
   import spart_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rxd = 1'b1;
   logic [15:0] baud_div = 16'd0;
   int          total = 0;
   int          bad = 0;
   int          cyc;
   logic [7:0]  exp_b [3];

   spart_rx_if bus ();

   spart_rx #(.OVERSAMPLE(16), .DIV_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_div (baud_div),
      .rxd      (rxd),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives start, 8 data bits LSB first, then the stop level (left on the line).
   task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
      rxd = 1'b0;
      step(bc);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         step(bc);
      end
      rxd = stop;
      step(bc);
   endtask

   task automatic wait_rda(input int limit, output int n);
      n = 0;
      while (!bus.rda && n <= limit) begin
         step(1);
         n++;
      end
   endtask

   task automatic ack();
      bus.rd_ack = 1'b1;
      step(1);
      bus.rd_ack = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [7:0] d, input logic r,
                            input logic fe, input logic ov);
      check({tag, "_data"}, 32'(bus.rx_data), 32'(d));
      check({tag, "_rda"},  32'(bus.rda), 32'(r));
      check({tag, "_fe"},   32'(bus.framing_err), 32'(fe));
      check({tag, "_ov"},   32'(bus.overrun), 32'(ov));
   endtask

   initial begin
      bus.rd_ack = 1'b0;
      exp_b[0] = 8'h00;
      exp_b[1] = 8'hFF;
      exp_b[2] = 8'h55;

      // Reset values
      step(3);
      check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      check("reset_state", 32'(dut.state), 32'(IDLE));
      rst_n = 1'b1;
      step(5);

      // Basic receive of 8'hA5 with latency window around 152 cycles
      fork
         send_frame(8'hA5, 1'b1, 16);
         wait_rda(200, cyc);
      join
      check("basic_latency_ok", 32'(cyc >= 150 && cyc <= 158), 32'd1);
      check_out("basic", 8'hA5, 1'b1, 1'b0, 1'b0);
      ack();
      check("basic_ack_rda", 32'(bus.rda), 32'd0);

      // 4-cycle glitch is rejected
      step(16);
      rxd = 1'b0;
      step(4);
      rxd = 1'b1;
      step(40);
      check("glitch_state", 32'(dut.state), 32'(IDLE));
      check_out("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);

      // Framing error, then line held low: no phantom 8'h00 frames
      send_frame(8'h3C, 1'b0, 16);
      check_out("frame", 8'h3C, 1'b1, 1'b1, 1'b0);
      step(48);
      rxd = 1'b1;
      step(200);
      check_out("break_hold", 8'h3C, 1'b1, 1'b1, 1'b0);
      ack();
      check_out("break_ack", 8'h3C, 1'b0, 1'b0, 1'b0);
      step(16);
      send_frame(8'h11, 1'b1, 16);
      step(4);
      check_out("after_break", 8'h11, 1'b1, 1'b0, 1'b0);
      ack();

      // Overrun: second byte dropped while rda still set
      step(16);
      send_frame(8'h01, 1'b1, 16);
      send_frame(8'h02, 1'b1, 16);
      step(4);
      check_out("overrun", 8'h01, 1'b1, 1'b0, 1'b1);
      ack();
      check_out("overrun_ack", 8'h01, 1'b0, 1'b0, 1'b0);

      // rd_ack on the exact completion cycle: new byte loaded, no overrun.
      // Completion edge is 155 edges after the drive edge (2 sync + 1 detect + 152).
      step(16);
      send_frame(8'h01, 1'b1, 16);
      step(4);
      check_out("pre_same", 8'h01, 1'b1, 1'b0, 1'b0);
      fork
         send_frame(8'h02, 1'b1, 16);
         begin
            step(154);
            bus.rd_ack = 1'b1;
            step(1);
            bus.rd_ack = 1'b0;
         end
      join
      step(2);
      check_out("same_cycle", 8'h02, 1'b1, 1'b0, 1'b0);

      // Reset during data bit 4 of a frame; byte 8'h02 still held beforehand
      step(16);
      fork
         send_frame(8'h96, 1'b1, 16);
         begin
            step(16 + 16*4 + 8);
            rst_n = 1'b0;
            step(2);
            check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
            check("mid_reset_state", 32'(dut.state), 32'(IDLE));
         end
      join
      rst_n = 1'b1;
      step(32);
      check_out("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b1, 16);
      step(4);
      check_out("post_reset_rx", 8'hC3, 1'b1, 1'b0, 1'b0);
      ack();

      // Baud mismatch: divisor 3 (64-cycle bit), transmitter at 62 and 66 cycles
      baud_div = 16'd3;
      step(20);
      for (int r = 0; r < 2; r++) begin
         fork
            begin
               for (int k = 0; k < 3; k++)
                  send_frame(exp_b[k], 1'b1, (r == 0) ? 62 : 66);
               step(64);
            end
            begin
               for (int k = 0; k < 3; k++) begin
                  int n;
                  wait_rda(1000, n);
                  check("mismatch_in_time", 32'(n <= 1000), 32'd1);
                  check_out("mismatch", exp_b[k], 1'b1, 1'b0, 1'b0);
                  ack();
               end
            end
         join
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
